// File: rtl/fetch_decode_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_decode_buffer_pkg
// Shared definitions for the fetch/decode instruction buffer: default NOP word,
// HALT opcode, FSM state encoding and the HALT-detection helper.
// -----------------------------------------------------------------------------
package fetch_decode_buffer_pkg;

    // Word presented to decode whenever no valid entry sits at the head.
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;

    // Opcode field value (instruction[15:11]) that identifies a HALT.
    localparam logic [4:0]  HALT_OPCODE       = 5'b00000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fdb_state_e;

    // True when the instruction word carries the HALT opcode.
    function automatic logic is_halt(input logic [15:0] instr);
        return (instr[15:11] == HALT_OPCODE);
    endfunction

endpackage

// File: rtl/fetch_decode_buffer_register_16bits.sv
// -----------------------------------------------------------------------------
// register_16bits
// 16-bit storage register with synchronous active-high reset and write enable.
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - synchronous active-high reset (clears contents to zero)
//   i_we   - write enable
//   i_d    - data to store
//   o_q    - stored value
// -----------------------------------------------------------------------------
module register_16bits (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [15:0] i_d,
    output logic [15:0] o_q
);

    logic [15:0] r_q;

    // Storage: contents only change on reset or an explicit write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 16'h0000;
        end else if (i_we) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_decode_buffer.sv
// -----------------------------------------------------------------------------
// fetch_decode_buffer
// Small FIFO of instruction/PC+2 pairs between fetch and decode. Freezes after a
// HALT has been handed to decode until a flush or reset.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   fetch_valid_in    - fetch offers instruction_in / pc_next_in this cycle
//   instruction_in    - fetched instruction word
//   pc_next_in        - PC+2 of instruction_in
//   decode_ready_in   - decode accepts the head entry this cycle
//   flush_in          - discard all entries and leave HALTED
//   instruction_out   - head instruction, NOP_INSTR when not valid
//   pc_next_out       - head PC+2, zero when not valid
//   valid_out         - head entry presented to decode
//   buffer_full_out   - occupancy == DEPTH, fetch must hold its PC
//   halted_out        - HALT handed to decode, buffer frozen
//   occupancy_out     - number of stored entries
// -----------------------------------------------------------------------------
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_in,
    input  logic [15:0] instruction_in,
    input  logic [15:0] pc_next_in,
    input  logic        decode_ready_in,
    input  logic        flush_in,
    output logic [15:0] instruction_out,
    output logic [15:0] pc_next_out,
    output logic        valid_out,
    output logic        buffer_full_out,
    output logic        halted_out,
    output logic [1:0]  occupancy_out
);

    // occupancy_out is 2 bits wide, so DEPTH is limited to 1..3.
    localparam int             PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [1:0]     DEPTH_CNT = 2'(DEPTH);

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : (p + PTR_W'(1));
    endfunction

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [1:0]       r_occ;
    fdb_state_e       r_state;
    fdb_state_e       w_state_next;

    logic             w_full;
    logic             w_halted;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_we;
    logic [15:0]      w_entry_instr [DEPTH];
    logic [15:0]      w_entry_pc    [DEPTH];
    logic [15:0]      w_head_instr;
    logic [15:0]      w_head_pc;

    // Status derived only from registered state: no input reaches these.
    assign w_full   = (r_occ == DEPTH_CNT);
    assign w_halted = (r_state == ST_HALTED);
    assign w_valid  = (r_occ != 2'd0) & ~w_halted;

    // Push is refused when full even if a pop frees a slot this cycle.
    assign w_push = fetch_valid_in & ~w_full & ~flush_in & ~w_halted;
    assign w_pop  = w_valid & decode_ready_in & ~flush_in;

    // Entry storage: one instruction and one PC register per slot.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign w_we[g] = w_push & (r_wr_ptr == PTR_W'(g));

        register_16bits u_instr_reg (
            .i_clk (clk),
            .i_rst (rst),
            .i_we  (w_we[g]),
            .i_d   (instruction_in),
            .o_q   (w_entry_instr[g])
        );

        register_16bits u_pc_reg (
            .i_clk (clk),
            .i_rst (rst),
            .i_we  (w_we[g]),
            .i_d   (pc_next_in),
            .o_q   (w_entry_pc[g])
        );
    end

    // Head-of-queue read mux selected by the read pointer.
    always_comb begin
        w_head_instr = 16'h0000;
        w_head_pc    = 16'h0000;
        for (int i = 0; i < DEPTH; i++) begin
            w_head_instr = (r_rd_ptr == PTR_W'(i)) ? w_entry_instr[i] : w_head_instr;
            w_head_pc    = (r_rd_ptr == PTR_W'(i)) ? w_entry_pc[i]    : w_head_pc;
        end
    end

    // Pointers and occupancy; flush discards everything, overriding push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_occ    <= 2'd0;
        end else if (flush_in) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_occ    <= 2'd0;
        end else begin
            r_wr_ptr <= w_push ? next_ptr(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? next_ptr(r_rd_ptr) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: a HALT leaving the head freezes the buffer until flush.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (flush_in) begin
                    w_state_next = ST_RUN;
                end else if (w_pop && is_halt(w_head_instr)) begin
                    w_state_next = ST_HALTED;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (flush_in) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_HALTED;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    // Output presentation: NOP/zero whenever the head is not valid.
    always_comb begin
        instruction_out = NOP_INSTR;
        pc_next_out     = 16'h0000;
        if (w_valid) begin
            instruction_out = w_head_instr;
            pc_next_out     = w_head_pc;
        end else begin
            instruction_out = NOP_INSTR;
            pc_next_out     = 16'h0000;
        end
    end

    assign valid_out       = w_valid;
    assign buffer_full_out = w_full;
    assign halted_out      = w_halted;
    assign occupancy_out   = r_occ;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
module tb_fetch_decode_buffer;

    localparam int          DEPTH = 2;
    localparam logic [15:0] NOP   = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid_in = 1'b0;
    logic [15:0] instruction_in = 16'h0000;
    logic [15:0] pc_next_in = 16'h0000;
    logic        decode_ready_in = 1'b0;
    logic        flush_in = 1'b0;
    logic [15:0] instruction_out;
    logic [15:0] pc_next_out;
    logic        valid_out;
    logic        buffer_full_out;
    logic        halted_out;
    logic [1:0]  occupancy_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the buffer as a plain queue plus a halted flag.
    logic [31:0] mdl_q[$];
    logic        mdl_halted = 1'b0;
    logic        started = 1'b0;
    // Scoreboard of handoffs decode is expected to see, in order.
    logic [31:0] exp_q[$];

    fetch_decode_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid_in  (fetch_valid_in),
        .instruction_in  (instruction_in),
        .pc_next_in      (pc_next_in),
        .decode_ready_in (decode_ready_in),
        .flush_in        (flush_in),
        .instruction_out (instruction_out),
        .pc_next_out     (pc_next_out),
        .valid_out       (valid_out),
        .buffer_full_out (buffer_full_out),
        .halted_out      (halted_out),
        .occupancy_out   (occupancy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at each clock edge, from the inputs seen at that edge.
    initial begin
        logic [31:0] h;
        logic        do_pop;
        logic        do_push;
        forever begin
            @(posedge clk);
            if (rst) begin
                mdl_q.delete();
                exp_q.delete();
                mdl_halted = 1'b0;
                started    = 1'b1;
            end else if (flush_in) begin
                mdl_q.delete();
                exp_q.delete();
                mdl_halted = 1'b0;
            end else if (!mdl_halted) begin
                do_pop  = (mdl_q.size() > 0) && decode_ready_in;
                do_push = fetch_valid_in && (mdl_q.size() < DEPTH);
                if (do_pop) begin
                    h = mdl_q.pop_front();
                    if (h[31:27] == 5'b00000) mdl_halted = 1'b1;
                end
                if (do_push) begin
                    mdl_q.push_back({instruction_in, pc_next_in});
                    exp_q.push_back({instruction_in, pc_next_in});
                end
            end
        end
    end

    // Monitor: status vs model every cycle; each DUT handoff pops the scoreboard.
    initial begin
        logic [31:0] e;
        logic        exp_valid;
        forever begin
            @(negedge clk);
            if (started) begin
                exp_valid = (mdl_q.size() > 0) && !mdl_halted;
                chk("valid_out", 32'(valid_out), 32'(exp_valid));
                chk("buffer_full_out", 32'(buffer_full_out), 32'(mdl_q.size() == DEPTH));
                chk("occupancy_out", 32'(occupancy_out), 32'(mdl_q.size()));
                chk("halted_out", 32'(halted_out), 32'(mdl_halted));
                if (!exp_valid) begin
                    chk("idle_instr", 32'(instruction_out), 32'(NOP));
                    chk("idle_pc", 32'(pc_next_out), 32'h0);
                end
                if (valid_out && decode_ready_in && !flush_in && !rst) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL handoff: got %h with nothing expected", instruction_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("handoff_instr", 32'(instruction_out), 32'(e[31:16]));
                        chk("handoff_pc", 32'(pc_next_out), 32'(e[15:0]));
                    end
                end
            end
        end
    end

    // Drive the inputs that the next clock edge will see.
    task automatic step(input logic fv, input logic [15:0] ins, input logic [15:0] pc,
                        input logic rdy, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        fetch_valid_in  = fv;
        instruction_in  = ins;
        pc_next_in      = pc;
        decode_ready_in = rdy;
        flush_in        = fl;
        rst             = rs;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 16'h0000, 16'h0000, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        #3;
        chk("rst_valid", 32'(valid_out), 32'h0);
        chk("rst_full", 32'(buffer_full_out), 32'h0);
        chk("rst_halted", 32'(halted_out), 32'h0);
        chk("rst_occ", 32'(occupancy_out), 32'h0);
        chk("rst_instr", 32'(instruction_out), 32'h0800);
        chk("rst_pc", 32'(pc_next_out), 32'h0);

        // Single push, visible one cycle later.
        step(1'b1, 16'h4001, 16'h0002, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        #3;
        chk("first_valid", 32'(valid_out), 32'h1);
        chk("first_instr", 32'(instruction_out), 32'h4001);
        chk("first_pc", 32'(pc_next_out), 32'h0002);
        idle(1'b0);

        // Fill with decode stalled; third push must be refused.
        step(1'b1, 16'hA001, 16'h0010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hA002, 16'h0012, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hA003, 16'h0014, 1'b0, 1'b0, 1'b0);
        #3;
        chk("fill_occ", 32'(occupancy_out), 32'h2);
        chk("fill_full", 32'(buffer_full_out), 32'h1);
        idle(1'b1);
        #3;
        chk("drain_head0", 32'(instruction_out), 32'hA001);
        idle(1'b1);
        #3;
        chk("drain_head1", 32'(instruction_out), 32'hA002);
        idle(1'b1);
        #3;
        chk("drain_empty", 32'(valid_out), 32'h0);

        // Flush with a competing push.
        step(1'b1, 16'h1111, 16'h0020, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 16'h0022, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h3333, 16'h0024, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        #3;
        chk("flush_occ", 32'(occupancy_out), 32'h0);
        chk("flush_valid", 32'(valid_out), 32'h0);
        chk("flush_instr", 32'(instruction_out), 32'h0800);

        // Steady push+pop at occupancy 1 across pointer wrap.
        step(1'b1, 16'hB000, 16'h0030, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 16'hB000 + 16'(i), 16'h0030 + 16'(2 * i), 1'b1, 1'b0, 1'b0);
            #3;
            chk("stream_occ", 32'(occupancy_out), 32'h1);
            chk("stream_head", 32'(instruction_out), 32'hB000 + 32'(i - 1));
        end
        idle(1'b1);
        idle(1'b1);

        // HALT freezes the buffer until flush.
        step(1'b1, 16'h0000, 16'h0040, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        step(1'b1, 16'hC001, 16'h0042, 1'b1, 1'b0, 1'b0);
        #3;
        chk("halt_set", 32'(halted_out), 32'h1);
        chk("halt_valid", 32'(valid_out), 32'h0);
        step(1'b1, 16'hC002, 16'h0044, 1'b1, 1'b0, 1'b0);
        #3;
        chk("halt_nopush", 32'(occupancy_out), 32'h0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        #3;
        chk("halt_clear", 32'(halted_out), 32'h0);
        chk("halt_clear_occ", 32'(occupancy_out), 32'h0);

        // Randomized traffic including HALTs, flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ins[15:11] = 5'b00000;
            step(1'($urandom_range(0, 3) != 0), ins, 16'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 199) == 0));
        end
        idle(1'b0);
        idle(1'b0);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 Parameter DEPTH, default 2, number of instruction entries held between fetch and decode.
REQ-002 Parameter NOP_INSTR, default 16'h0800, instruction word driven while no valid entry is presented.
REQ-003 One clock; reset is synchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 fetch_valid_in  input  1  fetch presents a valid instruction/PC pair this cycle (low while instruction memory stalls).
REQ-007 instruction_in  input  16  fetched instruction word.
REQ-008 pc_next_in  input  16  PC+2 associated with instruction_in.
REQ-009 decode_ready_in  input  1  decode accepts the head entry this cycle (low on hazard stall).
REQ-010 flush_in  input  1  branch/jump resolved taken; discard all buffered entries.
REQ-011 instruction_out  output  16  head instruction, or NOP_INSTR when valid_out is low.
REQ-012 pc_next_out  output  16  head PC+2, or 16'h0000 when valid_out is low.
REQ-013 valid_out  output  1  head entry valid and presented to decode.
REQ-014 buffer_full_out  output  1  occupancy equals DEPTH; fetch SHALL hold its PC.
REQ-015 halted_out  output  1  a HALT has been handed to decode; buffer frozen.
REQ-016 occupancy_out  output  2  current number of valid entries (0..DEPTH).

Function
REQ-017 Push occurs iff fetch_valid_in & ~buffer_full_out & ~flush_in & ~halted_out; entry written at write pointer, visible at outputs the following cycle (1-cycle latency).
REQ-018 Pop occurs iff valid_out & decode_ready_in & ~flush_in; read pointer advances at the clock edge.
REQ-019 buffer_full_out and valid_out SHALL be functions of registered state only (no combinational path from any input).
REQ-020 Simultaneous push and pop with 0 < occupancy < DEPTH leaves occupancy unchanged; at occupancy DEPTH the push is refused even if a pop occurs that cycle.
REQ-021 Pointers are log2(DEPTH)-bit and wrap from DEPTH-1 to 0; occupancy counter never exceeds DEPTH nor underflows below 0.
REQ-022 valid_out = (occupancy != 0) & ~halted_out; when low, instruction_out = NOP_INSTR and pc_next_out = 0.
REQ-023 flush_in clears occupancy and both pointers at the next edge, overrides any same-cycle push or pop, and returns the FSM to RUN.
REQ-024 FSM states RUN and HALTED; RUN -> HALTED when an entry with instruction[15:11] == 5'b00000 is popped; HALTED -> RUN only on flush_in or rst.
REQ-025 In HALTED no push or pop occurs, stored entries are retained, halted_out = 1.
REQ-026 Entry contents are not altered by a refused push or by decode_ready_in low.

Reset
REQ-027 On rst: occupancy 0, pointers 0, FSM RUN; outputs valid_out 0, buffer_full_out 0, halted_out 0, occupancy_out 0, instruction_out NOP_INSTR, pc_next_out 16'h0000.
REQ-028 rst dominates flush_in, push and pop in the same cycle; entries in flight are discarded.

Structure
REQ-029 Shared package holds NOP_INSTR default 16'h0800, HALT opcode 5'b00000, and the RUN/HALTED state encoding.
REQ-030 Entry storage uses the existing register_16bits sub-module, one instance per instruction word and one per PC per entry, write-enabled by the decoded write pointer.

Verification
REQ-031 Reset, then fetch_valid_in=1 with instr 16'h4001, pc 16'h0002, decode_ready_in=1 -> next cycle valid_out=1, instruction_out=16'h4001, pc_next_out=16'h0002.
REQ-032 decode_ready_in=0, push 16'hA001 then 16'hA002 -> occupancy_out=2, buffer_full_out=1; third push 16'hA003 refused; on release, decode sees A001, A002 in order, never A003.
REQ-033 Occupancy 2, flush_in=1 with fetch_valid_in=1 -> next cycle occupancy_out=0, valid_out=0, instruction_out=16'h0800.
REQ-034 Occupancy 1 with simultaneous push and pop over 10 cycles across pointer wrap -> occupancy_out stays 1, instructions emerge in push order.
REQ-035 Pop of 16'h0000 -> halted_out=1 next cycle, valid_out=0, further pushes ignored; flush_in then returns halted_out=0 with occupancy 0.
